// File: rtl/nasti_lite_write_resp_merge.sv
// Merges the N single-beat lite B responses of one split NASTI write burst
// into a single NASTI B response, using burst descriptors queued by the splitter.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | no burst in progress, waiting for a queued descriptor
// COLLECT | accepting lite B beats for the head descriptor
// RESP    | presenting the merged NASTI B response, holding until ready
module nasti_lite_write_resp_merge #(
    parameter int ID_WIDTH   = 1,
    parameter int USER_WIDTH = 1,
    parameter int CNT_WIDTH  = 9,
    parameter int DESC_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ID_WIDTH-1:0]   desc_id,
    input  logic [USER_WIDTH-1:0] desc_user,
    input  logic [CNT_WIDTH-1:0]  desc_cnt,
    input  logic                  desc_valid,
    output logic                  desc_ready,
    input  logic [ID_WIDTH-1:0]   lite_b_id,
    input  logic [1:0]            lite_b_resp,
    input  logic [USER_WIDTH-1:0] lite_b_user,
    input  logic                  lite_b_valid,
    output logic                  lite_b_ready,
    output logic [ID_WIDTH-1:0]   nasti_b_id,
    output logic [1:0]            nasti_b_resp,
    output logic [USER_WIDTH-1:0] nasti_b_user,
    output logic                  nasti_b_valid,
    input  logic                  nasti_b_ready,
    output logic                  id_err
);

    localparam int PTR_W = (DESC_DEPTH > 1) ? $clog2(DESC_DEPTH) : 1;
    localparam int OCC_W = $clog2(DESC_DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DESC_DEPTH - 1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DESC_DEPTH);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_RESP    = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [ID_WIDTH-1:0]   r_fifo_id   [DESC_DEPTH];
    logic [USER_WIDTH-1:0] r_fifo_user [DESC_DEPTH];
    logic [CNT_WIDTH-1:0]  r_fifo_cnt  [DESC_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [OCC_W-1:0]      r_occ;

    logic [CNT_WIDTH-1:0]  r_remaining;
    logic [1:0]            r_acc;
    logic [ID_WIDTH-1:0]   r_b_id;
    logic [1:0]            r_b_resp;
    logic [USER_WIDTH-1:0] r_b_user;
    logic                  r_id_err;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_lite_hs;
    logic                  w_last_beat;
    logic                  w_load;
    logic [ID_WIDTH-1:0]   w_head_id;
    logic [USER_WIDTH-1:0] w_head_user;
    logic [CNT_WIDTH-1:0]  w_head_cnt;
    logic [1:0]            w_mapped;
    logic [1:0]            w_acc_next;
    logic                  w_unused;

    assign w_unused    = ^lite_b_user;

    assign w_full      = (r_occ == OCC_FULL);
    assign w_empty     = (r_occ == '0);
    assign desc_ready  = !rst && !w_full;
    assign w_push      = desc_valid && desc_ready;

    assign w_head_id   = r_fifo_id[r_rd_ptr];
    assign w_head_user = r_fifo_user[r_rd_ptr];
    // A zero count still means one lite response is coming.
    assign w_head_cnt  = (r_fifo_cnt[r_rd_ptr] == '0) ? CNT_ONE : r_fifo_cnt[r_rd_ptr];

    assign w_lite_hs   = lite_b_valid && lite_b_ready;
    assign w_last_beat = w_lite_hs && (r_remaining == CNT_ONE);
    assign w_pop       = w_last_beat;

    // EXOKAY folds to OKAY; the remaining codes are already ordered by severity.
    assign w_mapped    = (lite_b_resp == 2'b01) ? 2'b00 : lite_b_resp;
    assign w_acc_next  = (w_mapped > r_acc) ? w_mapped : r_acc;

    assign w_load      = (r_state != S_COLLECT) && (w_state_next == S_COLLECT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_state_next = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (w_last_beat) begin
                    w_state_next = S_RESP;
                end
            end
            S_RESP: begin
                if (nasti_b_ready) begin
                    w_state_next = w_empty ? S_IDLE : S_COLLECT;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        lite_b_ready  = 1'b0;
        nasti_b_valid = 1'b0;
        case (r_state)
            S_COLLECT: lite_b_ready  = 1'b1;
            S_RESP:    nasti_b_valid = 1'b1;
            default: begin
                lite_b_ready  = 1'b0;
                nasti_b_valid = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_id[r_wr_ptr]   <= desc_id;
            r_fifo_user[r_wr_ptr] <= desc_user;
            r_fifo_cnt[r_wr_ptr]  <= desc_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_occ <= r_occ + 1'b1;
            end else if (w_pop && !w_push) begin
                r_occ <= r_occ - 1'b1;
            end
        end
    end

    // The pop happens on entry to RESP, so a reload from RESP reads the next burst.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_remaining <= '0;
            r_acc       <= 2'b00;
            r_b_id      <= '0;
            r_b_resp    <= 2'b00;
            r_b_user    <= '0;
            r_id_err    <= 1'b0;
        end else begin
            r_id_err <= w_lite_hs && (lite_b_id != w_head_id);
            if (w_load) begin
                r_remaining <= w_head_cnt;
                r_acc       <= 2'b00;
            end else if (w_lite_hs) begin
                r_remaining <= r_remaining - CNT_ONE;
                r_acc       <= w_acc_next;
            end
            if (w_last_beat) begin
                r_b_id   <= w_head_id;
                r_b_user <= w_head_user;
                r_b_resp <= w_acc_next;
            end
        end
    end

    assign nasti_b_id   = r_b_id;
    assign nasti_b_resp = r_b_resp;
    assign nasti_b_user = r_b_user;
    assign id_err       = r_id_err;

endmodule

// File: tb/tb_nasti_lite_write_resp_merge.sv
// Bench for nasti_lite_write_resp_merge: table of bursts with known merged
// responses, hand sequences for latency, backpressure, FIFO-full and reset.
module tb_nasti_lite_write_resp_merge;

    logic       clk = 1'b0;
    logic       rst;
    logic [0:0] desc_id;
    logic [0:0] desc_user;
    logic [8:0] desc_cnt;
    logic       desc_valid;
    logic       desc_ready;
    logic [0:0] lite_b_id;
    logic [1:0] lite_b_resp;
    logic [0:0] lite_b_user;
    logic       lite_b_valid;
    logic       lite_b_ready;
    logic [0:0] nasti_b_id;
    logic [1:0] nasti_b_resp;
    logic [0:0] nasti_b_user;
    logic       nasti_b_valid;
    logic       nasti_b_ready;
    logic       id_err;

    always #5 clk = ~clk;

    nasti_lite_write_resp_merge #(
        .ID_WIDTH   (1),
        .USER_WIDTH (1),
        .CNT_WIDTH  (9),
        .DESC_DEPTH (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .desc_id       (desc_id),
        .desc_user     (desc_user),
        .desc_cnt      (desc_cnt),
        .desc_valid    (desc_valid),
        .desc_ready    (desc_ready),
        .lite_b_id     (lite_b_id),
        .lite_b_resp   (lite_b_resp),
        .lite_b_user   (lite_b_user),
        .lite_b_valid  (lite_b_valid),
        .lite_b_ready  (lite_b_ready),
        .nasti_b_id    (nasti_b_id),
        .nasti_b_resp  (nasti_b_resp),
        .nasti_b_user  (nasti_b_user),
        .nasti_b_valid (nasti_b_valid),
        .nasti_b_ready (nasti_b_ready),
        .id_err        (id_err)
    );

    typedef struct {
        logic [0:0] id;
        logic [0:0] user;
        logic [1:0] resp;
    } exp_t;

    typedef struct {
        logic [0:0] id;
        logic [0:0] user;
        logic [8:0] cnt;
        int         nbeats;
        logic [7:0] resps;
        logic [3:0] bad;
        logic [1:0] exp_resp;
        int         exp_iderr;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[7];
    int   checks = 0;
    int   failures = 0;
    int   iderr_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_b(input logic [0:0] id, input logic [0:0] user, input logic [1:0] resp);
        exp_t e;
        e.id = id;
        e.user = user;
        e.resp = resp;
        exp_q.push_back(e);
    endtask

    // Scoreboard side: every merged response is compared against the queue head.
    always @(negedge clk) begin
        if (!rst) begin
            if (id_err) iderr_seen++;
            if (nasti_b_valid) chk("lite_ready_in_resp", 32'(lite_b_ready), 32'd0);
            if (nasti_b_valid && nasti_b_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_b: got id=%0h resp=%0h, required no response", nasti_b_id, nasti_b_resp);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("b_id", 32'(nasti_b_id), 32'(e.id));
                    chk("b_resp", 32'(nasti_b_resp), 32'(e.resp));
                    chk("b_user", 32'(nasti_b_user), 32'(e.user));
                end
            end
        end
    end

    task automatic push_desc(input logic [0:0] id, input logic [0:0] user, input logic [8:0] cnt);
        int n;
        desc_id = id;
        desc_user = user;
        desc_cnt = cnt;
        desc_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!desc_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!desc_ready) chk("desc_push_timeout", 32'(desc_ready), 32'd1);
        @(posedge clk);
        #1;
        desc_valid = 1'b0;
    endtask

    task automatic lite_beat(input logic [0:0] id, input logic [1:0] resp);
        int n;
        lite_b_id = id;
        lite_b_resp = resp;
        lite_b_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!lite_b_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!lite_b_ready) chk("lite_beat_timeout", 32'(lite_b_ready), 32'd1);
        chk("no_early_b", 32'(nasti_b_valid), 32'd0);
        @(posedge clk);
        #1;
        lite_b_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #300000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{id: 1'b0, user: 1'b0, cnt: 9'd4, nbeats: 4, resps: 8'b01_00_10_00, bad: 4'b0000, exp_resp: 2'd2, exp_iderr: 0};
        vecs[1] = '{id: 1'b0, user: 1'b0, cnt: 9'd2, nbeats: 2, resps: 8'b00_00_11_10, bad: 4'b0010, exp_resp: 2'd3, exp_iderr: 1};
        vecs[2] = '{id: 1'b1, user: 1'b0, cnt: 9'd3, nbeats: 3, resps: 8'b00_01_01_01, bad: 4'b0000, exp_resp: 2'd0, exp_iderr: 0};
        vecs[3] = '{id: 1'b1, user: 1'b1, cnt: 9'd0, nbeats: 1, resps: 8'b00_00_00_11, bad: 4'b0000, exp_resp: 2'd3, exp_iderr: 0};
        vecs[4] = '{id: 1'b0, user: 1'b1, cnt: 9'd2, nbeats: 2, resps: 8'b00_00_00_11, bad: 4'b0001, exp_resp: 2'd3, exp_iderr: 1};
        vecs[5] = '{id: 1'b1, user: 1'b0, cnt: 9'd1, nbeats: 1, resps: 8'b00_00_00_10, bad: 4'b0000, exp_resp: 2'd2, exp_iderr: 0};
        vecs[6] = '{id: 1'b0, user: 1'b1, cnt: 9'd3, nbeats: 3, resps: 8'b00_01_10_01, bad: 4'b0000, exp_resp: 2'd2, exp_iderr: 0};

        rst = 1'b1;
        desc_id = '0;
        desc_user = '0;
        desc_cnt = '0;
        desc_valid = 1'b0;
        lite_b_id = '0;
        lite_b_resp = 2'd0;
        lite_b_user = '0;
        lite_b_valid = 1'b0;
        nasti_b_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("desc_ready_in_rst", 32'(desc_ready), 32'd0);
        chk("rst_b_valid", 32'(nasti_b_valid), 32'd0);
        chk("rst_lite_ready", 32'(lite_b_ready), 32'd0);
        chk("rst_id_err", 32'(id_err), 32'd0);
        chk("rst_b_fields", 32'({nasti_b_id, nasti_b_resp, nasti_b_user}), 32'd0);
        rst = 1'b0;
        #1;
        chk("desc_ready_after_rst", 32'(desc_ready), 32'd1);

        // Single beat with exact latencies
        expect_b(1'b1, 1'b0, 2'd0);
        desc_id = 1'b1;
        desc_user = 1'b0;
        desc_cnt = 9'd1;
        desc_valid = 1'b1;
        @(posedge clk);
        #1;
        desc_valid = 1'b0;
        chk("idle_gap_lite_ready", 32'(lite_b_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("collect_at_t2", 32'(lite_b_ready), 32'd1);
        lite_b_id = 1'b1;
        lite_b_resp = 2'd0;
        lite_b_valid = 1'b1;
        @(posedge clk);
        #1;
        lite_b_valid = 1'b0;
        chk("single_b_valid", 32'(nasti_b_valid), 32'd1);
        chk("single_b_id", 32'(nasti_b_id), 32'd1);
        chk("single_b_resp", 32'(nasti_b_resp), 32'd0);
        @(posedge clk);
        #1;
        chk("single_b_done", 32'(nasti_b_valid), 32'd0);
        chk("single_back_idle", 32'(lite_b_ready), 32'd0);
        wait_drain("single_drain");

        // Table-driven bursts
        for (int i = 0; i < 7; i++) begin
            iderr_seen = 0;
            expect_b(vecs[i].id, vecs[i].user, vecs[i].exp_resp);
            push_desc(vecs[i].id, vecs[i].user, vecs[i].cnt);
            for (int b = 0; b < vecs[i].nbeats; b++) begin
                lite_beat(vecs[i].bad[b] ? ~vecs[i].id : vecs[i].id, vecs[i].resps[2*b +: 2]);
            end
            wait_drain($sformatf("vec%0d_drain", i));
            repeat (2) @(posedge clk);
            #1;
            chk($sformatf("vec%0d_id_err", i), 32'(iderr_seen), 32'(vecs[i].exp_iderr));
        end

        // Backpressure: response held stable, stray lite beat not consumed
        nasti_b_ready = 1'b0;
        expect_b(1'b1, 1'b1, 2'd2);
        push_desc(1'b1, 1'b1, 9'd1);
        lite_beat(1'b1, 2'd2);
        lite_b_id = 1'b0;
        lite_b_resp = 2'd3;
        lite_b_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            chk("bp_valid", 32'(nasti_b_valid), 32'd1);
            chk("bp_fields", 32'({nasti_b_id, nasti_b_resp, nasti_b_user}), 32'b1_10_1);
            chk("bp_lite_ready", 32'(lite_b_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        nasti_b_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release", 32'(nasti_b_valid), 32'd0);
        chk("bp_stray_not_taken", 32'(lite_b_ready), 32'd0);
        lite_b_valid = 1'b0;
        wait_drain("bp_drain");

        // FIFO full: third descriptor stalls until the first burst pops
        expect_b(1'b0, 1'b0, 2'd0);
        expect_b(1'b1, 1'b0, 2'd2);
        expect_b(1'b0, 1'b0, 2'd3);
        desc_user = 1'b0;
        desc_cnt = 9'd1;
        desc_id = 1'b0;
        desc_valid = 1'b1;
        @(posedge clk);
        #1;
        desc_id = 1'b1;
        @(posedge clk);
        #1;
        chk("fifo_full_ready", 32'(desc_ready), 32'd0);
        desc_id = 1'b0;
        fork
            begin
                int n;
                n = 0;
                @(negedge clk);
                while (!desc_ready && n < 200) begin
                    @(negedge clk);
                    n++;
                end
                chk("third_stall_cycles", 32'(n), 32'd1);
                @(posedge clk);
                #1;
                desc_valid = 1'b0;
            end
            begin
                lite_beat(1'b0, 2'd0);
                lite_beat(1'b1, 2'd2);
                lite_beat(1'b0, 2'd3);
            end
        join
        wait_drain("fifo_full_drain");

        // Reset in the middle of a burst
        push_desc(1'b1, 1'b0, 9'd4);
        lite_beat(1'b1, 2'd3);
        lite_beat(1'b1, 2'd3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_b_valid", 32'(nasti_b_valid), 32'd0);
        chk("midrst_lite_ready", 32'(lite_b_ready), 32'd0);
        chk("midrst_desc_ready", 32'(desc_ready), 32'd0);
        chk("midrst_b_fields", 32'({nasti_b_id, nasti_b_resp, nasti_b_user}), 32'd0);
        rst = 1'b0;
        #1;
        chk("midrst_fifo_empty", 32'(desc_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        chk("midrst_stays_idle", 32'(lite_b_ready), 32'd0);
        expect_b(1'b0, 1'b0, 2'd0);
        push_desc(1'b0, 1'b0, 9'd1);
        lite_beat(1'b0, 2'd0);
        wait_drain("post_rst_drain");
        repeat (2) @(posedge clk);
        #1;
        chk("post_rst_idle", 32'(lite_b_ready), 32'd0);
        chk("post_rst_no_b", 32'(nasti_b_valid), 32'd0);

        chk("queue_empty_end", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
